apu_ahbl_manager: RTL and testbench

//  - AHB-Lite manager for the APU. Turns an in-order valid/ready command stream into AHB-Lite single

---
 rtl/apu_ahbl_manager_pkg.sv | 31 +++
 rtl/apu_ahbl_lane_steer.sv | 37 +++
 rtl/apu_ahbl_manager.sv | 105 ++++++++++
 tb/tb_apu_ahbl_manager.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/apu_ahbl_manager_pkg.sv
// Shared AHB-Lite encodings, pipeline slot layout and the local-error rule
// for the APU AHB-Lite manager.
package apu_ahbl_manager_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  typedef struct packed {
    logic       valid;
    logic       lerr;
    logic       write;
    logic [2:0] size;
    logic [1:0] addr_lo;
  } slot_t;

  // Commands that can never be a legal AHB transfer stay in the pipeline as
  // placeholders so their error response keeps its place in the order.
  function automatic logic is_local_err(input logic [2:0] size, input logic [1:0] addr_lo);
    case (size)
      HSIZE_BYTE: is_local_err = 1'b0;
      HSIZE_HALF: is_local_err = addr_lo[0];
      HSIZE_WORD: is_local_err = (addr_lo != 2'b00);
      default:    is_local_err = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/apu_ahbl_lane_steer.sv
// Byte-lane steering: write-data replication and read-data shift/mask,
// keyed on transfer size and the low address bits.
module apu_ahbl_lane_steer
  import apu_ahbl_manager_pkg::*;
(
  input  logic [2:0]  i_size,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_hrdata,
  output logic [31:0] o_hwdata,
  output logic [31:0] o_rdata
);

  logic [31:0] w_shifted;

  assign w_shifted = i_hrdata >> {i_addr_lo, 3'b000};

  always_comb begin
    o_hwdata = i_wdata;
    o_rdata  = w_shifted;
    case (i_size)
      HSIZE_BYTE: begin
        o_hwdata = {4{i_wdata[7:0]}};
        o_rdata  = {24'd0, w_shifted[7:0]};
      end
      HSIZE_HALF: begin
        o_hwdata = {2{i_wdata[15:0]}};
        o_rdata  = {16'd0, w_shifted[15:0]};
      end
      default: begin
        o_hwdata = i_wdata;
        o_rdata  = w_shifted;
      end
    endcase
  end

endmodule

// File: rtl/apu_ahbl_manager.sv
// AHB-Lite manager: valid/ready commands become single NONSEQ transfers with
// pipelined address (A) and data (D) slots; one in-order response per command.
module apu_ahbl_manager
  import apu_ahbl_manager_pkg::*;
#(
  parameter int W_ADDR = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [W_ADDR-1:0] cmd_addr,
  input  logic              cmd_write,
  input  logic [2:0]        cmd_size,
  input  logic [31:0]       cmd_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [W_ADDR-1:0] ahblm_haddr,
  output logic [1:0]        ahblm_htrans,
  output logic              ahblm_hwrite,
  output logic [2:0]        ahblm_hsize,
  input  logic              ahblm_hready,
  output logic [31:0]       ahblm_hwdata,
  input  logic [31:0]       ahblm_hrdata,
  input  logic              ahblm_hresp
);

  slot_t             r_a;
  slot_t             r_d;
  logic [W_ADDR-1:0] r_a_haddr;
  logic [31:0]       r_a_wdata;
  logic [31:0]       r_d_wdata;
  logic              r_rsp_valid;
  logic              r_rsp_err;
  logic [31:0]       r_rsp_rdata;

  logic              w_err1;
  logic              w_cmd_fire;
  logic [31:0]       w_rdata;

  // First cycle of a two-cycle ERROR response from the slave in D.
  assign w_err1     = r_d.valid && ahblm_hresp && !ahblm_hready;
  assign cmd_ready  = ahblm_hready && !w_err1;
  assign w_cmd_fire = cmd_valid && cmd_ready;

  apu_ahbl_lane_steer u_lane_steer (
    .i_size    (r_d.size),
    .i_addr_lo (r_d.addr_lo),
    .i_wdata   (r_d_wdata),
    .i_hrdata  (ahblm_hrdata),
    .o_hwdata  (ahblm_hwdata),
    .o_rdata   (w_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a         <= '0;
      r_d         <= '0;
      r_a_haddr   <= '0;
      r_a_wdata   <= '0;
      r_d_wdata   <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
      // Cancel the pending address phase; it still answers with an error later.
      if (w_err1 && r_a.valid) begin
        r_a.lerr <= 1'b1;
      end
      if (ahblm_hready) begin
        r_d       <= r_a;
        r_d_wdata <= r_a_wdata;
        if (w_cmd_fire) begin
          r_a.valid   <= 1'b1;
          r_a.lerr    <= is_local_err(cmd_size, cmd_addr[1:0]);
          r_a.write   <= cmd_write;
          r_a.size    <= cmd_size;
          r_a.addr_lo <= cmd_addr[1:0];
          r_a_haddr   <= cmd_addr;
          r_a_wdata   <= cmd_write ? cmd_wdata : 32'd0;
        end else begin
          r_a <= '0;
        end
        if (r_d.valid) begin
          r_rsp_valid <= 1'b1;
          r_rsp_err   <= ahblm_hresp | r_d.lerr;
          r_rsp_rdata <= (ahblm_hresp || r_d.lerr || r_d.write) ? 32'd0 : w_rdata;
        end
      end
    end
  end

  assign ahblm_haddr  = r_a_haddr;
  assign ahblm_htrans = (r_a.valid && !r_a.lerr) ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign ahblm_hwrite = r_a.write;
  assign ahblm_hsize  = r_a.size;
  assign rsp_valid    = r_rsp_valid;
  assign rsp_err      = r_rsp_err;
  assign rsp_rdata    = r_rsp_rdata;

endmodule

// File: tb/tb_apu_ahbl_manager.sv
// Directed bench for apu_ahbl_manager: the testbench acts as the AHB slave and
// checks bus and response timing against hand-computed values.
module tb_apu_ahbl_manager;

  localparam int W_ADDR = 16;

  logic              clk;
  logic              rst_n;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [W_ADDR-1:0] cmd_addr;
  logic              cmd_write;
  logic [2:0]        cmd_size;
  logic [31:0]       cmd_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic [W_ADDR-1:0] ahblm_haddr;
  logic [1:0]        ahblm_htrans;
  logic              ahblm_hwrite;
  logic [2:0]        ahblm_hsize;
  logic              ahblm_hready;
  logic [31:0]       ahblm_hwdata;
  logic [31:0]       ahblm_hrdata;
  logic              ahblm_hresp;

  int checks;
  int failures;

  apu_ahbl_manager #(.W_ADDR(W_ADDR)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_addr     (cmd_addr),
    .cmd_write    (cmd_write),
    .cmd_size     (cmd_size),
    .cmd_wdata    (cmd_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .ahblm_haddr  (ahblm_haddr),
    .ahblm_htrans (ahblm_htrans),
    .ahblm_hwrite (ahblm_hwrite),
    .ahblm_hsize  (ahblm_hsize),
    .ahblm_hready (ahblm_hready),
    .ahblm_hwdata (ahblm_hwdata),
    .ahblm_hrdata (ahblm_hrdata),
    .ahblm_hresp  (ahblm_hresp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [15:0] addr, input logic wr, input logic [2:0] size,
                       input logic [31:0] wdata);
    cmd_valid = 1'b1;
    cmd_addr  = addr;
    cmd_write = wr;
    cmd_size  = size;
    cmd_wdata = wdata;
  endtask

  task automatic chk_rsp(input string tag, input logic v, input logic e, input logic [31:0] d);
    chk({tag, ".rsp_valid"}, {31'd0, rsp_valid}, {31'd0, v});
    chk({tag, ".rsp_err"},   {31'd0, rsp_err},   {31'd0, e});
    chk({tag, ".rsp_rdata"}, rsp_rdata, d);
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    rst_n        = 1'b0;
    cmd_valid    = 1'b0;
    cmd_addr     = '0;
    cmd_write    = 1'b0;
    cmd_size     = 3'd0;
    cmd_wdata    = '0;
    ahblm_hready = 1'b1;
    ahblm_hrdata = '0;
    ahblm_hresp  = 1'b0;

    tick();
    tick();
    chk("rst.htrans", {30'd0, ahblm_htrans}, 32'd0);
    chk("rst.haddr",  {16'd0, ahblm_haddr}, 32'd0);
    chk("rst.hwrite", {31'd0, ahblm_hwrite}, 32'd0);
    chk("rst.hsize",  {29'd0, ahblm_hsize}, 32'd0);
    chk("rst.hwdata", ahblm_hwdata, 32'd0);
    chk_rsp("rst", 1'b0, 1'b0, 32'd0);
    rst_n = 1'b1;
    tick();

    // 1: word write, zero wait states
    offer(16'h0010, 1'b1, 3'd2, 32'hdeadbeef);
    #1 chk("t1.cmd_ready", {31'd0, cmd_ready}, 32'd1);
    tick();
    cmd_valid = 1'b0;
    chk("t1.htrans", {30'd0, ahblm_htrans}, 32'h2);
    chk("t1.haddr",  {16'd0, ahblm_haddr}, 32'h0010);
    chk("t1.hwrite", {31'd0, ahblm_hwrite}, 32'd1);
    chk("t1.hsize",  {29'd0, ahblm_hsize}, 32'd2);
    chk("t1.rsp_early", {31'd0, rsp_valid}, 32'd0);
    tick();
    chk("t1.hwdata", ahblm_hwdata, 32'hdeadbeef);
    chk("t1.htrans_idle", {30'd0, ahblm_htrans}, 32'd0);
    chk("t1.rsp_early2", {31'd0, rsp_valid}, 32'd0);
    tick();
    chk_rsp("t1", 1'b1, 1'b0, 32'd0);
    tick();
    chk("t1.rsp_pulse", {31'd0, rsp_valid}, 32'd0);

    // 2: three back-to-back word reads
    offer(16'h0020, 1'b0, 3'd2, 32'd0);
    tick();
    chk("t2.htrans0", {30'd0, ahblm_htrans}, 32'h2);
    chk("t2.haddr0",  {16'd0, ahblm_haddr}, 32'h0020);
    offer(16'h0024, 1'b0, 3'd2, 32'd0);
    tick();
    chk("t2.htrans1", {30'd0, ahblm_htrans}, 32'h2);
    chk("t2.haddr1",  {16'd0, ahblm_haddr}, 32'h0024);
    ahblm_hrdata = 32'h11;
    offer(16'h0028, 1'b0, 3'd2, 32'd0);
    tick();
    chk("t2.htrans2", {30'd0, ahblm_htrans}, 32'h2);
    chk("t2.haddr2",  {16'd0, ahblm_haddr}, 32'h0028);
    chk_rsp("t2.r0", 1'b1, 1'b0, 32'h11);
    cmd_valid    = 1'b0;
    ahblm_hrdata = 32'h22;
    tick();
    chk_rsp("t2.r1", 1'b1, 1'b0, 32'h22);
    ahblm_hrdata = 32'h33;
    tick();
    chk_rsp("t2.r2", 1'b1, 1'b0, 32'h33);
    ahblm_hrdata = 32'h0;
    tick();
    chk("t2.rsp_end", {31'd0, rsp_valid}, 32'd0);

    // 3: byte read lane extraction, halfword write replication
    offer(16'h0013, 1'b0, 3'd0, 32'd0);
    tick();
    cmd_valid = 1'b0;
    chk("t3.htrans", {30'd0, ahblm_htrans}, 32'h2);
    chk("t3.hsize",  {29'd0, ahblm_hsize}, 32'd0);
    tick();
    ahblm_hrdata = 32'hab000000;
    tick();
    chk_rsp("t3.byte", 1'b1, 1'b0, 32'h000000ab);
    ahblm_hrdata = 32'h0;
    offer(16'h0002, 1'b1, 3'd1, 32'h00001234);
    tick();
    cmd_valid = 1'b0;
    chk("t3.hsize_half", {29'd0, ahblm_hsize}, 32'd1);
    tick();
    chk("t3.hwdata", ahblm_hwdata, 32'h12341234);
    tick();
    chk_rsp("t3.half", 1'b1, 1'b0, 32'd0);
    tick();

    // 4: misaligned halfword followed by aligned word read
    offer(16'h0001, 1'b0, 3'd1, 32'd0);
    tick();
    chk("t4.no_xfer", {30'd0, ahblm_htrans}, 32'd0);
    offer(16'h0004, 1'b0, 3'd2, 32'd0);
    tick();
    cmd_valid = 1'b0;
    chk("t4.htrans", {30'd0, ahblm_htrans}, 32'h2);
    chk("t4.haddr",  {16'd0, ahblm_haddr}, 32'h0004);
    ahblm_hrdata = 32'h55aa55aa;
    tick();
    chk_rsp("t4.lerr", 1'b1, 1'b1, 32'd0);
    tick();
    chk_rsp("t4.ok", 1'b1, 1'b0, 32'h55aa55aa);
    ahblm_hrdata = 32'h0;
    tick();

    // 5: three wait states with a command pending in A and another offered
    offer(16'h0030, 1'b0, 3'd2, 32'd0);
    tick();
    offer(16'h0034, 1'b0, 3'd2, 32'd0);
    tick();
    offer(16'h0038, 1'b0, 3'd2, 32'd0);
    ahblm_hready = 1'b0;
    #1 chk("t5.ready_w0", {31'd0, cmd_ready}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("t5.haddr_w%0d", i), {16'd0, ahblm_haddr}, 32'h0034);
      chk($sformatf("t5.htrans_w%0d", i), {30'd0, ahblm_htrans}, 32'h2);
      chk($sformatf("t5.rsp_w%0d", i), {31'd0, rsp_valid}, 32'd0);
      if (i < 2) chk($sformatf("t5.ready_w%0d", i + 1), {31'd0, cmd_ready}, 32'd0);
    end
    ahblm_hready = 1'b1;
    ahblm_hrdata = 32'h77;
    #1 chk("t5.ready_go", {31'd0, cmd_ready}, 32'd1);
    tick();
    cmd_valid = 1'b0;
    chk_rsp("t5.r0", 1'b1, 1'b0, 32'h77);
    chk("t5.haddr_next", {16'd0, ahblm_haddr}, 32'h0038);
    ahblm_hrdata = 32'h88;
    tick();
    chk_rsp("t5.r1", 1'b1, 1'b0, 32'h88);
    ahblm_hrdata = 32'h99;
    tick();
    chk_rsp("t5.r2", 1'b1, 1'b0, 32'h99);
    ahblm_hrdata = 32'h0;
    tick();

    // 6: two-cycle error on a write with a read waiting in A
    offer(16'h0040, 1'b1, 3'd2, 32'h00000001);
    tick();
    offer(16'h0044, 1'b0, 3'd2, 32'd0);
    tick();
    cmd_valid    = 1'b0;
    ahblm_hready = 1'b0;
    ahblm_hresp  = 1'b1;
    #1 chk("t6.ready_err1", {31'd0, cmd_ready}, 32'd0);
    tick();
    chk("t6.htrans_cancel", {30'd0, ahblm_htrans}, 32'd0);
    chk("t6.rsp_none", {31'd0, rsp_valid}, 32'd0);
    ahblm_hready = 1'b1;
    tick();
    ahblm_hresp = 1'b0;
    chk_rsp("t6.werr", 1'b1, 1'b1, 32'd0);
    tick();
    chk_rsp("t6.rerr", 1'b1, 1'b1, 32'd0);
    tick();
    chk("t6.rsp_end", {31'd0, rsp_valid}, 32'd0);

    // reset asserted while a read sits in a wait state
    offer(16'h0050, 1'b0, 3'd2, 32'd0);
    tick();
    cmd_valid = 1'b0;
    tick();
    ahblm_hready = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    chk("rstm.htrans", {30'd0, ahblm_htrans}, 32'd0);
    chk("rstm.haddr",  {16'd0, ahblm_haddr}, 32'd0);
    chk("rstm.hwdata", ahblm_hwdata, 32'd0);
    chk_rsp("rstm", 1'b0, 1'b0, 32'd0);
    tick();
    ahblm_hready = 1'b1;
    ahblm_hrdata = 32'hcafef00d;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("rstm.no_rsp%0d", i), {31'd0, rsp_valid}, 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
